// File: rtl/niosii_system_nios2_0_oci_dct_packer_pkg.sv
// Shared widths and FSM encoding for the OCI DCT trace-atom packer.
package niosii_system_nios2_0_oci_dct_packer_pkg;
   localparam int unsigned ATOM_W         = 2;
   localparam int unsigned ATOMS_PER_WORD = 15;
   localparam int unsigned DCT_W          = ATOM_W * ATOMS_PER_WORD;
   localparam int unsigned CNT_W          = 4;

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_DRAIN,
      ST_ENDING,
      ST_ENDED
   } state_e;
endpackage

// File: rtl/niosii_system_nios2_0_oci_dct_packer_if.sv
// Atom input, DCT word output and end-of-test signals of the packer.
interface niosii_system_nios2_0_oci_dct_packer_if;
   import niosii_system_nios2_0_oci_dct_packer_pkg::*;

   logic              atom_valid;
   logic [ATOM_W-1:0] atom_data;
   logic              atom_ready;
   logic              flush;
   logic              end_req;
   logic              dct_valid;
   logic              dct_ready;
   logic [DCT_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_ending;
   logic              test_has_ended;

   modport master (
      input  atom_valid, atom_data, flush, end_req, dct_ready,
      output atom_ready, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended
   );

   modport slave (
      output atom_valid, atom_data, flush, end_req, dct_ready,
      input  atom_ready, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended
   );
endinterface

// File: rtl/niosii_system_nios2_0_oci_dct_packer_shifter.sv
// Collect register: shifts accepted atoms in at the LSB end and counts them.
module niosii_system_nios2_0_oci_dct_shifter
   import niosii_system_nios2_0_oci_dct_packer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              accept_i,
   input  logic [ATOM_W-1:0] atom_i,
   input  logic              clear_i,
   output logic [DCT_W-1:0]  col_buf_o,
   output logic [CNT_W-1:0]  col_cnt_o,
   output logic              full_o,
   output logic [DCT_W-1:0]  next_buf_o,
   output logic [CNT_W-1:0]  next_cnt_o
);
   logic [DCT_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DCT_W-1:0] next_buf;
   logic [CNT_W-1:0] next_cnt;

   // next_* include the atom accepted this cycle; the top transfers these
   always_comb begin
      next_buf = buf_q;
      next_cnt = cnt_q;
      if (accept_i) begin
         next_buf = {buf_q[DCT_W-ATOM_W-1:0], atom_i};
         next_cnt = cnt_q + CNT_W'(1);
      end
      buf_d = clear_i ? '0 : next_buf;
      cnt_d = clear_i ? '0 : next_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign col_buf_o  = buf_q;
   assign col_cnt_o  = cnt_q;
   assign full_o     = (cnt_q == CNT_W'(ATOMS_PER_WORD));
   assign next_buf_o = next_buf;
   assign next_cnt_o = next_cnt;
endmodule

// File: rtl/niosii_system_nios2_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT words with an output holding
// register, pending-flush tracking and the end-of-test sequencer.
module niosii_system_nios2_0_oci_dct_packer
   import niosii_system_nios2_0_oci_dct_packer_pkg::*;
(
   input  logic clk,
   input  logic reset,
   niosii_system_nios2_0_oci_dct_packer_if.master bus
);
   state_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic             valid_q, valid_d;
   logic [DCT_W-1:0] obuf_q, obuf_d;
   logic [CNT_W-1:0] ocnt_q, ocnt_d;

   logic             atom_ready;
   logic             accept;
   logic             xfer;
   logic             trig;
   logic             out_free;
   logic             flush_any;
   logic             has_data;
   logic [DCT_W-1:0] col_buf;
   logic [CNT_W-1:0] col_cnt;
   logic             col_full;
   logic [DCT_W-1:0] nxt_buf;
   logic [CNT_W-1:0] nxt_cnt;

   niosii_system_nios2_0_oci_dct_shifter u_shift (
      .clk        (clk),
      .reset      (reset),
      .accept_i   (accept),
      .atom_i     (bus.atom_data),
      .clear_i    (xfer),
      .col_buf_o  (col_buf),
      .col_cnt_o  (col_cnt),
      .full_o     (col_full),
      .next_buf_o (nxt_buf),
      .next_cnt_o (nxt_cnt)
   );

   // A full collect word refuses atoms even when it can move out this
   // cycle, otherwise the accepted atom would overflow the 15-atom word.
   always_comb begin
      out_free   = !valid_q || bus.dct_ready;
      atom_ready = (state_q == ST_COLLECT) && !pend_q && !col_full;
      accept     = bus.atom_valid && atom_ready;
      flush_any  = bus.flush || bus.end_req;
      has_data   = (nxt_cnt != '0);

      trig = 1'b0;
      case (state_q)
         ST_COLLECT: trig = (nxt_cnt == CNT_W'(ATOMS_PER_WORD)) ||
                            (has_data && (pend_q || flush_any));
         ST_DRAIN:   trig = has_data;
         default:    trig = 1'b0;
      endcase
      xfer = trig && out_free;

      pend_d = pend_q;
      if (xfer)
         pend_d = 1'b0;
      else if ((state_q == ST_COLLECT) && flush_any && has_data)
         pend_d = 1'b1;

      state_d = state_q;
      case (state_q)
         ST_COLLECT: if (bus.end_req) state_d = ST_DRAIN;
         ST_DRAIN:   if ((col_cnt == '0) && out_free) state_d = ST_ENDING;
         ST_ENDING:  state_d = ST_ENDED;
         default:    state_d = ST_ENDED;
      endcase

      valid_d = valid_q;
      obuf_d  = obuf_q;
      ocnt_d  = ocnt_q;
      if (xfer) begin
         valid_d = 1'b1;
         obuf_d  = nxt_buf;
         ocnt_d  = nxt_cnt;
      end else if (valid_q && bus.dct_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_COLLECT;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         obuf_q  <= '0;
         ocnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         obuf_q  <= obuf_d;
         ocnt_q  <= ocnt_d;
      end
   end

   assign bus.atom_ready     = atom_ready;
   assign bus.dct_valid      = valid_q;
   assign bus.dct_buffer     = obuf_q;
   assign bus.dct_count      = ocnt_q;
   assign bus.test_ending    = (state_q == ST_ENDING);
   assign bus.test_has_ended = (state_q == ST_ENDED);
endmodule

// File: tb/tb_niosii_system_nios2_0_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer.
module tb_niosii_system_nios2_0_oci_dct_packer;
   import niosii_system_nios2_0_oci_dct_packer_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   niosii_system_nios2_0_oci_dct_packer_if bus ();

   niosii_system_nios2_0_oci_dct_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.atom_valid = 1'b0;
      bus.atom_data  = 2'b00;
      bus.flush      = 1'b0;
      bus.end_req    = 1'b0;
   endtask

   task automatic send_atom(input logic [1:0] d);
      bus.atom_valid = 1'b1;
      bus.atom_data  = d;
      @(negedge clk);
      bus.atom_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.dct_ready = 1'b1;
      do_reset();
      tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", bus.dct_valid); end
      tests++; if (bus.dct_buffer !== 30'h0) begin fails++; $display("FAIL rst_buffer: got %h want 0", bus.dct_buffer); end
      tests++; if (bus.dct_count !== 4'h0) begin fails++; $display("FAIL rst_count: got %h want 0", bus.dct_count); end
      tests++; if (bus.test_ending !== 1'b0 || bus.test_has_ended !== 1'b0) begin fails++; $display("FAIL rst_end: got %0b%0b want 00", bus.test_ending, bus.test_has_ended); end
      tests++; if (bus.atom_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b want 1", bus.atom_ready); end
   endtask

   task automatic test_full_word();
      bus.dct_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 14) begin
            tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL full_early: got %0b want 0", bus.dct_valid); end
         end
         bus.atom_valid = 1'b1;
         bus.atom_data  = 2'b01;
         @(negedge clk);
      end
      bus.atom_valid = 1'b0;
      tests++; if (bus.dct_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %0b want 1", bus.dct_valid); end
      tests++; if (bus.dct_count !== 4'hF) begin fails++; $display("FAIL full_count: got %h want f", bus.dct_count); end
      tests++; if (bus.dct_buffer !== 30'h15555555) begin fails++; $display("FAIL full_buffer: got %h want 15555555", bus.dct_buffer); end
      @(negedge clk);
      tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL full_drain: got %0b want 0", bus.dct_valid); end
      tests++; if (dut.col_cnt !== 4'h0) begin fails++; $display("FAIL full_colcnt: got %h want 0", dut.col_cnt); end
   endtask

   task automatic test_flush();
      bus.dct_ready = 1'b1;
      send_atom(2'b11);
      send_atom(2'b10);
      send_atom(2'b01);
      tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL flush_early: got %0b want 0", bus.dct_valid); end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      tests++; if (bus.dct_valid !== 1'b1 || bus.dct_count !== 4'h3) begin fails++; $display("FAIL flush_word: got v=%0b c=%h want v=1 c=3", bus.dct_valid, bus.dct_count); end
      tests++; if (bus.dct_buffer !== 30'h39) begin fails++; $display("FAIL flush_buffer: got %h want 39", bus.dct_buffer); end
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL flush_empty: got %0b want 0", bus.dct_valid); end
      @(negedge clk);
      tests++; if (bus.dct_valid !== 1'b0) begin fails++; $display("FAIL flush_empty2: got %0b want 0", bus.dct_valid); end
   endtask

   task automatic test_atom_flush();
      bus.dct_ready = 1'b1;
      send_atom(2'b00);
      send_atom(2'b01);
      send_atom(2'b00);
      send_atom(2'b01);
      bus.atom_valid = 1'b1;
      bus.atom_data  = 2'b10;
      bus.flush      = 1'b1;
      @(negedge clk);
      idle_inputs();
      tests++; if (bus.dct_valid !== 1'b1 || bus.dct_count !== 4'h5) begin fails++; $display("FAIL atomflush_word: got v=%0b c=%h want v=1 c=5", bus.dct_valid, bus.dct_count); end
      tests++; if (bus.dct_buffer !== 30'h046) begin fails++; $display("FAIL atomflush_buffer: got %h want 046", bus.dct_buffer); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [1:0] d;
      bus.dct_ready = 1'b0;
      for (int i = 0; i < 31; i++) begin
         d = 2'(i % 4);
         tests++; if (bus.atom_ready !== (i < 30)) begin fails++; $display("FAIL bp_ready%0d: got %0b want %0b", i, bus.atom_ready, (i < 30)); end
         bus.atom_valid = 1'b1;
         bus.atom_data  = d;
         @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         tests++; if (bus.dct_valid !== 1'b1 || bus.dct_buffer !== 30'h06C6C6C6 || bus.dct_count !== 4'hF) begin fails++; $display("FAIL bp_hold%0d: got v=%0b b=%h c=%h want v=1 b=06c6c6c6 c=f", k, bus.dct_valid, bus.dct_buffer, bus.dct_count); end
         tests++; if (bus.atom_ready !== 1'b0) begin fails++; $display("FAIL bp_stall%0d: got %0b want 0", k, bus.atom_ready); end
         @(negedge clk);
      end
      bus.dct_ready = 1'b1;
      @(negedge clk);
      tests++; if (bus.dct_valid !== 1'b1 || bus.dct_buffer !== 30'h31B1B1B1 || bus.dct_count !== 4'hF) begin fails++; $display("FAIL bp_word2: got v=%0b b=%h c=%h want v=1 b=31b1b1b1 c=f", bus.dct_valid, bus.dct_buffer, bus.dct_count); end
      tests++; if (bus.atom_ready !== 1'b1) begin fails++; $display("FAIL bp_resume: got %0b want 1", bus.atom_ready); end
      @(negedge clk);
      bus.atom_valid = 1'b0;
      bus.flush      = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      tests++; if (bus.dct_valid !== 1'b1 || bus.dct_buffer !== 30'h2 || bus.dct_count !== 4'h1) begin fails++; $display("FAIL bp_word3: got v=%0b b=%h c=%h want v=1 b=2 c=1", bus.dct_valid, bus.dct_buffer, bus.dct_count); end
      @(negedge clk);
   endtask

   task automatic test_end();
      bus.dct_ready = 1'b1;
      for (int i = 0; i < 7; i++) send_atom(2'b11);
      bus.end_req   = 1'b1;
      bus.dct_ready = 1'b0;
      @(negedge clk);
      bus.end_req = 1'b0;
      tests++; if (bus.atom_ready !== 1'b0) begin fails++; $display("FAIL end_ready: got %0b want 0", bus.atom_ready); end
      for (int k = 0; k < 5; k++) begin
         tests++; if (bus.dct_valid !== 1'b1 || bus.dct_count !== 4'h7 || bus.dct_buffer !== 30'h3FFF) begin fails++; $display("FAIL end_hold%0d: got v=%0b b=%h c=%h want v=1 b=3fff c=7", k, bus.dct_valid, bus.dct_buffer, bus.dct_count); end
         tests++; if (bus.test_ending !== 1'b0) begin fails++; $display("FAIL end_early%0d: got %0b want 0", k, bus.test_ending); end
         if (k < 4) @(negedge clk);
      end
      bus.dct_ready = 1'b1;
      @(negedge clk);
      tests++; if (bus.test_ending !== 1'b1 || bus.dct_valid !== 1'b0) begin fails++; $display("FAIL end_pulse: got te=%0b v=%0b want te=1 v=0", bus.test_ending, bus.dct_valid); end
      bus.end_req = 1'b1;
      bus.flush   = 1'b1;
      @(negedge clk);
      idle_inputs();
      tests++; if (bus.test_ending !== 1'b0 || bus.test_has_ended !== 1'b1) begin fails++; $display("FAIL end_ended: got te=%0b th=%0b want te=0 th=1", bus.test_ending, bus.test_has_ended); end
      @(negedge clk);
      tests++; if (bus.test_has_ended !== 1'b1 || bus.atom_ready !== 1'b0 || bus.dct_valid !== 1'b0) begin fails++; $display("FAIL end_sticky: got th=%0b r=%0b v=%0b want th=1 r=0 v=0", bus.test_has_ended, bus.atom_ready, bus.dct_valid); end
   endtask

   task automatic test_reset_mid_drain();
      bus.dct_ready = 1'b0;
      do_reset();
      send_atom(2'b01);
      send_atom(2'b01);
      send_atom(2'b01);
      bus.end_req = 1'b1;
      @(negedge clk);
      bus.end_req = 1'b0;
      tests++; if (bus.dct_valid !== 1'b1 || dut.state_q !== ST_DRAIN) begin fails++; $display("FAIL mid_setup: got v=%0b s=%0d want v=1 s=%0d", bus.dct_valid, dut.state_q, ST_DRAIN); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++; if (bus.dct_valid !== 1'b0 || bus.dct_buffer !== 30'h0 || bus.dct_count !== 4'h0) begin fails++; $display("FAIL mid_outputs: got v=%0b b=%h c=%h want 0", bus.dct_valid, bus.dct_buffer, bus.dct_count); end
      tests++; if (bus.atom_ready !== 1'b1 || dut.state_q !== ST_COLLECT) begin fails++; $display("FAIL mid_state: got r=%0b s=%0d want r=1 s=%0d", bus.atom_ready, dut.state_q, ST_COLLECT); end
      tests++; if (bus.test_ending !== 1'b0 || bus.test_has_ended !== 1'b0) begin fails++; $display("FAIL mid_end: got %0b%0b want 00", bus.test_ending, bus.test_has_ended); end
   endtask

   initial begin
      idle_inputs();
      bus.dct_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_full_word();
      test_flush();
      test_atom_flush();
      test_back_to_back();
      test_end();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
